csr_master: RTL and testbench

CSR_MASTER -- requirements
Module: csr_master

---
 rtl/csr_master.sv | 126 ++++++++++++
 tb/tb_csr_master.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_master.sv
// Zicsr read-modify-write sequencer between the execute stage and a CSR responder.
// Latency: rsp_valid 3 cycles after acceptance when a write occurs, 2 cycles otherwise.
// Backpressure: req_ready only in IDLE; the response is held stable until rsp_ready.
module csr_master #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_funct3,
    input  logic [11:0]     req_addr,
    input  logic [XLEN-1:0] req_rs1_data,
    input  logic [4:0]      req_rs1_idx,
    output logic [11:0]     rif_addr,
    input  logic [XLEN-1:0] rif_rdata,
    input  logic            rif_ro,
    input  logic            rif_exception,
    output logic            wif_valid,
    output logic [11:0]     wif_addr,
    output logic [XLEN-1:0] wif_data,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_exception
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_e;

    state_e            state_q, state_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [11:0]       addr_q, addr_d;
    logic [XLEN-1:0]   operand_q, operand_d;
    logic [4:0]        rs1_idx_q, rs1_idx_d;
    logic [XLEN-1:0]   old_q, old_d;
    logic [XLEN-1:0]   new_q, new_d;
    logic              exc_q, exc_d;

    logic              write_req;
    logic              illegal;
    logic [XLEN-1:0]   new_val;

    // Set/clear with rs1 = x0 (or uimm = 0) is a pure read and must not write.
    always_comb begin
        write_req = (funct3_q[1:0] == 2'b01) || (rs1_idx_q != 5'd0);
        illegal   = (funct3_q == 3'b000) || (funct3_q == 3'b100) ||
                    rif_exception || (write_req && rif_ro);
        case (funct3_q[1:0])
            2'b01:   new_val = operand_q;
            2'b10:   new_val = rif_rdata | operand_q;
            2'b11:   new_val = rif_rdata & ~operand_q;
            default: new_val = rif_rdata;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        funct3_d  = funct3_q;
        addr_d    = addr_q;
        operand_d = operand_q;
        rs1_idx_d = rs1_idx_q;
        old_d     = old_q;
        new_d     = new_q;
        exc_d     = exc_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    funct3_d  = req_funct3;
                    addr_d    = req_addr;
                    rs1_idx_d = req_rs1_idx;
                    operand_d = req_funct3[2] ? {{(XLEN-5){1'b0}}, req_rs1_idx} : req_rs1_data;
                    state_d   = READ;
                end
            end
            READ: begin
                old_d   = illegal ? '0 : rif_rdata;
                new_d   = new_val;
                exc_d   = illegal;
                state_d = (write_req && !illegal) ? WRITE : RESP;
            end
            WRITE: begin
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            funct3_q  <= '0;
            addr_q    <= '0;
            operand_q <= '0;
            rs1_idx_q <= '0;
            old_q     <= '0;
            new_q     <= '0;
            exc_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            funct3_q  <= funct3_d;
            addr_q    <= addr_d;
            operand_q <= operand_d;
            rs1_idx_q <= rs1_idx_d;
            old_q     <= old_d;
            new_q     <= new_d;
            exc_q     <= exc_d;
        end
    end

    assign req_ready     = (state_q == IDLE);
    assign rif_addr      = addr_q;
    assign wif_valid     = (state_q == WRITE);
    assign wif_addr      = addr_q;
    assign wif_data      = new_q;
    assign rsp_valid     = (state_q == RESP);
    assign rsp_rdata     = old_q;
    assign rsp_exception = (state_q == RESP) && exc_q;

endmodule

// File: tb/tb_csr_master.sv
// Bench for csr_master: plays the CSR responder and checks each request against a transaction-level CSR model.
module tb_csr_master;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            req_valid;
    logic            req_ready;
    logic [2:0]      req_funct3;
    logic [11:0]     req_addr;
    logic [XLEN-1:0] req_rs1_data;
    logic [4:0]      req_rs1_idx;
    logic [11:0]     rif_addr;
    logic [XLEN-1:0] rif_rdata;
    logic            rif_ro;
    logic            rif_exception;
    logic            wif_valid;
    logic [11:0]     wif_addr;
    logic [XLEN-1:0] wif_data;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [XLEN-1:0] rsp_rdata;
    logic            rsp_exception;

    logic [31:0] csr_mem   [0:4095];
    logic [31:0] model_mem [0:4095];
    logic        exc_force;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    // Responder: combinational read, top-two-address-bits 11 marks a read-only CSR.
    assign rif_rdata     = csr_mem[rif_addr];
    assign rif_ro        = (rif_addr[11:10] == 2'b11);
    assign rif_exception = exc_force;

    csr_master #(.XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_rs1_data(req_rs1_data), .req_rs1_idx(req_rs1_idx),
        .rif_addr(rif_addr), .rif_rdata(rif_rdata), .rif_ro(rif_ro), .rif_exception(rif_exception),
        .wif_valid(wif_valid), .wif_addr(wif_addr), .wif_data(wif_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_exception(rsp_exception)
    );

    task automatic preset(input logic [11:0] a, input logic [31:0] v);
        csr_mem[a]   = v;
        model_mem[a] = v;
    endtask

    // Reference: one Zicsr instruction applied to the model CSR file.
    task automatic predict(input logic [2:0] f3, input logic [11:0] a, input logic [31:0] d,
                           input logic [4:0] idx, output logic [31:0] e_rdata, output logic e_exc,
                           output int e_nwr, output logic [31:0] e_wdata, output int e_lat);
        logic [31:0] op, old, nv;
        logic        wr, ill;
        op  = f3[2] ? {27'd0, idx} : d;
        old = model_mem[a];
        wr  = (f3[1:0] == 2'b01) || (idx != 5'd0);
        ill = (f3[1:0] == 2'b00) || exc_force || (wr && a[11:10] == 2'b11);
        case (f3[1:0])
            2'b01:   nv = op;
            2'b10:   nv = old | op;
            default: nv = old & ~op;
        endcase
        e_exc   = ill;
        e_rdata = ill ? 32'd0 : old;
        e_nwr   = (wr && !ill) ? 1 : 0;
        e_wdata = nv;
        e_lat   = (e_nwr == 1) ? 3 : 2;
        if (e_nwr == 1) model_mem[a] = nv;
    endtask

    // Drives one request and records what the DUT did; latency counts cycles from the accept cycle.
    task automatic run_txn(input logic [2:0] f3, input logic [11:0] a, input logic [31:0] d,
                           input logic [4:0] idx, input int stall,
                           output int lat, output int nwr, output logic [11:0] waddr,
                           output logic [31:0] wdata, output logic [31:0] rdata, output logic exc,
                           output bit stable_ok, output bit idle_after, output bit to);
        int wait_cyc;
        lat = 0; nwr = 0; waddr = '0; wdata = '0; rdata = '0; exc = 1'b0;
        stable_ok = 1'b1; idle_after = 1'b0; to = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_funct3 = f3; req_addr = a; req_rs1_data = d; req_rs1_idx = idx;
        rsp_ready = 1'b0;
        wait_cyc = 0;
        while (!req_ready && wait_cyc < 20) begin
            @(negedge clk);
            wait_cyc++;
        end
        if (!req_ready) begin
            req_valid = 1'b0;
            to = 1'b1;
            return;
        end
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (wif_valid) begin
                nwr++;
                waddr = wif_addr;
                wdata = wif_data;
                csr_mem[wif_addr] = wif_data;
            end
            if (rsp_valid) begin
                lat = i;
                break;
            end
        end
        if (lat == 0) begin
            to = 1'b1;
            return;
        end
        rdata = rsp_rdata;
        exc   = rsp_exception;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            if (!rsp_valid || rsp_rdata !== rdata || rsp_exception !== exc ||
                req_ready !== 1'b0 || wif_valid !== 1'b0) stable_ok = 1'b0;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        idle_after = req_ready && !rsp_valid;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({req_ready, rsp_valid, wif_valid, rsp_exception} !== 4'b1000) begin
            $display("FAIL reset_ctrl got rdy/rsp/wif/exc=%b want 1000",
                     {req_ready, rsp_valid, wif_valid, rsp_exception});
        end else n_pass++;
        n_checks++;
        if (rsp_rdata !== 32'd0 || wif_data !== 32'd0 || rif_addr !== 12'd0 || wif_addr !== 12'd0) begin
            $display("FAIL reset_data got rdata=%h wdata=%h raddr=%h waddr=%h want all 0",
                     rsp_rdata, wif_data, rif_addr, wif_addr);
        end else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            $display("FAIL post_reset_idle got rdy=%b rsp=%b want 1 0", req_ready, rsp_valid);
        end else n_pass++;
    endtask

    task automatic test_csrrw_mtvec;
        int lat, nwr, elat, enwr;
        logic [11:0] wa; logic [31:0] wd, rd, erd, ewd; logic ex, eex; bit st, ia, to;
        preset(12'h305, 32'd0);
        predict(3'b001, 12'h305, 32'h8000_0100, 5'd1, erd, eex, enwr, ewd, elat);
        run_txn(3'b001, 12'h305, 32'h8000_0100, 5'd1, 0, lat, nwr, wa, wd, rd, ex, st, ia, to);
        n_checks++;
        if (to || lat != 3) $display("FAIL rw_latency got %0d (timeout=%0b) want 3", lat, to);
        else n_pass++;
        n_checks++;
        if (nwr != 1 || wa !== 12'h305 || wd !== 32'h8000_0100)
            $display("FAIL rw_write got n=%0d addr=%h data=%h want 1 305 80000100", nwr, wa, wd);
        else n_pass++;
        n_checks++;
        if (rd !== 32'd0 || ex !== 1'b0) $display("FAIL rw_rsp got rdata=%h exc=%b want 0 0", rd, ex);
        else n_pass++;
    endtask

    task automatic test_csrrs_ro_read;
        int lat, nwr, elat, enwr;
        logic [11:0] wa; logic [31:0] wd, rd, erd, ewd; logic ex, eex; bit st, ia, to;
        preset(12'hF14, 32'd0);
        predict(3'b010, 12'hF14, 32'hDEAD_BEEF, 5'd0, erd, eex, enwr, ewd, elat);
        run_txn(3'b010, 12'hF14, 32'hDEAD_BEEF, 5'd0, 0, lat, nwr, wa, wd, rd, ex, st, ia, to);
        n_checks++;
        if (to || lat != 2) $display("FAIL rs_ro_latency got %0d (timeout=%0b) want 2", lat, to);
        else n_pass++;
        n_checks++;
        if (nwr != 0 || ex !== 1'b0 || rd !== 32'd0)
            $display("FAIL rs_ro_rsp got n=%0d exc=%b rdata=%h want 0 0 0", nwr, ex, rd);
        else n_pass++;
    endtask

    task automatic test_csrrwi_ro;
        int lat, nwr, elat, enwr;
        logic [11:0] wa; logic [31:0] wd, rd, erd, ewd; logic ex, eex; bit st, ia, to;
        preset(12'hF11, 32'h1234_5678);
        predict(3'b101, 12'hF11, 32'h0, 5'd5, erd, eex, enwr, ewd, elat);
        run_txn(3'b101, 12'hF11, 32'h0, 5'd5, 0, lat, nwr, wa, wd, rd, ex, st, ia, to);
        n_checks++;
        if (to || nwr != 0 || ex !== 1'b1 || rd !== 32'd0)
            $display("FAIL rwi_ro got to=%0b n=%0d exc=%b rdata=%h want 0 0 1 0", to, nwr, ex, rd);
        else n_pass++;
    endtask

    task automatic test_csrrc_stall;
        int lat, nwr, elat, enwr;
        logic [11:0] wa; logic [31:0] wd, rd, erd, ewd; logic ex, eex; bit st, ia, to;
        preset(12'h342, 32'h0000_00FF);
        predict(3'b011, 12'h342, 32'h0000_000F, 5'd7, erd, eex, enwr, ewd, elat);
        run_txn(3'b011, 12'h342, 32'h0000_000F, 5'd7, 4, lat, nwr, wa, wd, rd, ex, st, ia, to);
        n_checks++;
        if (to || nwr != 1 || wd !== 32'h0000_00F0)
            $display("FAIL rc_write got to=%0b n=%0d data=%h want 0 1 000000f0", to, nwr, wd);
        else n_pass++;
        n_checks++;
        if (rd !== 32'h0000_00FF) $display("FAIL rc_rdata got %h want 000000ff", rd);
        else n_pass++;
        n_checks++;
        if (!st) $display("FAIL rc_stall_stable got unstable outputs want stable with req_ready=0");
        else n_pass++;
        n_checks++;
        if (!ia) $display("FAIL rc_idle_after got not idle want req_ready=1 after handshake");
        else n_pass++;
    endtask

    task automatic test_illegal;
        int lat, nwr, elat, enwr;
        logic [11:0] wa; logic [31:0] wd, rd, erd, ewd; logic ex, eex; bit st, ia, to;
        preset(12'h300, 32'h0000_1800);
        run_txn(3'b100, 12'h300, 32'hFFFF_FFFF, 5'd3, 1, lat, nwr, wa, wd, rd, ex, st, ia, to);
        n_checks++;
        if (to || nwr != 0 || ex !== 1'b1 || rd !== 32'd0 || lat != 2)
            $display("FAIL f3_100 got to=%0b n=%0d exc=%b rdata=%h lat=%0d want 0 0 1 0 2",
                     to, nwr, ex, rd, lat);
        else n_pass++;
        run_txn(3'b000, 12'h300, 32'hFFFF_FFFF, 5'd3, 0, lat, nwr, wa, wd, rd, ex, st, ia, to);
        n_checks++;
        if (to || nwr != 0 || ex !== 1'b1)
            $display("FAIL f3_000 got to=%0b n=%0d exc=%b want 0 0 1", to, nwr, ex);
        else n_pass++;
        exc_force = 1'b1;
        predict(3'b001, 12'h300, 32'h5, 5'd1, erd, eex, enwr, ewd, elat);
        run_txn(3'b001, 12'h300, 32'h5, 5'd1, 0, lat, nwr, wa, wd, rd, ex, st, ia, to);
        exc_force = 1'b0;
        n_checks++;
        if (to || nwr != 0 || ex !== 1'b1 || csr_mem[12'h300] !== 32'h0000_1800)
            $display("FAIL rif_exception got to=%0b n=%0d exc=%b mem=%h want 0 0 1 00001800",
                     to, nwr, ex, csr_mem[12'h300]);
        else n_pass++;
    endtask

    task automatic test_reset_mid_write;
        bit seen, bad;
        preset(12'h340, 32'h0000_1111);
        @(negedge clk);
        req_valid = 1'b1; req_funct3 = 3'b001; req_addr = 12'h340;
        req_rs1_data = 32'h0000_ABCD; req_rs1_idx = 5'd2; rsp_ready = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (wif_valid) begin
                seen = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!seen) $display("FAIL midrst_reach_write got no wif_valid want a write cycle");
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (wif_valid !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'd0)
            $display("FAIL midrst_abort got wif=%b rdy=%b rsp=%b rdata=%h want 0 1 0 0",
                     wif_valid, req_ready, rsp_valid, rsp_rdata);
        else n_pass++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid || wif_valid || !req_ready) bad = 1'b1;
        end
        n_checks++;
        if (bad || csr_mem[12'h340] !== 32'h0000_1111)
            $display("FAIL midrst_quiet got activity=%0b mem=%h want 0 00001111", bad, csr_mem[12'h340]);
        else n_pass++;
    endtask

    function automatic logic [11:0] pick_addr(input int k);
        case (k)
            0: pick_addr = 12'h305;
            1: pick_addr = 12'h340;
            2: pick_addr = 12'h341;
            3: pick_addr = 12'h342;
            4: pick_addr = 12'hF11;
            5: pick_addr = 12'hF14;
            6: pick_addr = 12'hC00;
            default: pick_addr = 12'h300;
        endcase
    endfunction

    task automatic test_random;
        int lat, nwr, elat, enwr, stall;
        logic [11:0] a, wa; logic [31:0] d, wd, rd, erd, ewd; logic ex, eex; bit st, ia, to;
        logic [2:0] f3; logic [4:0] idx;
        for (int k = 0; k < 8; k++) preset(pick_addr(k), $urandom);
        for (int n = 0; n < 40; n++) begin
            f3    = 3'($urandom_range(0, 7));
            a     = pick_addr($urandom_range(0, 7));
            d     = $urandom;
            idx   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            stall = $urandom_range(0, 3);
            exc_force = ($urandom_range(0, 7) == 0);
            predict(f3, a, d, idx, erd, eex, enwr, ewd, elat);
            run_txn(f3, a, d, idx, stall, lat, nwr, wa, wd, rd, ex, st, ia, to);
            exc_force = 1'b0;
            n_checks++;
            if (to || lat != elat || nwr != enwr)
                $display("FAIL rnd%0d timing got to=%0b lat=%0d n=%0d want 0 %0d %0d",
                         n, to, lat, nwr, elat, enwr);
            else n_pass++;
            if (enwr == 1) begin
                n_checks++;
                if (wa !== a || wd !== ewd)
                    $display("FAIL rnd%0d wif got addr=%h data=%h want %h %h", n, wa, wd, a, ewd);
                else n_pass++;
            end
            n_checks++;
            if (rd !== erd || ex !== eex)
                $display("FAIL rnd%0d rsp got rdata=%h exc=%b want %h %b", n, rd, ex, erd, eex);
            else n_pass++;
            n_checks++;
            if (!st || !ia)
                $display("FAIL rnd%0d handshake got stable=%0b idle_after=%0b want 1 1", n, st, ia);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back;
        int lat, nwr, elat, enwr;
        logic [11:0] wa; logic [31:0] d, wd, rd, erd, ewd; logic ex, eex; bit st, ia, to;
        preset(12'h341, 32'h0);
        for (int n = 0; n < 6; n++) begin
            d = $urandom;
            predict(3'b001, 12'h341, d, 5'd9, erd, eex, enwr, ewd, elat);
            run_txn(3'b001, 12'h341, d, 5'd9, 0, lat, nwr, wa, wd, rd, ex, st, ia, to);
            n_checks++;
            if (to || !ia || rd !== erd || wd !== ewd)
                $display("FAIL b2b%0d got to=%0b idle=%0b rdata=%h wdata=%h want 0 1 %h %h",
                         n, to, ia, rd, wd, erd, ewd);
            else n_pass++;
        end
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_funct3 = '0; req_addr = '0;
        req_rs1_data = '0; req_rs1_idx = '0; rsp_ready = 1'b0; exc_force = 1'b0;
        for (int i = 0; i < 4096; i++) begin
            csr_mem[i]   = 32'd0;
            model_mem[i] = 32'd0;
        end
        test_reset;
        test_csrrw_mtvec;
        test_csrrs_ro_read;
        test_csrrwi_ro;
        test_csrrc_stall;
        test_illegal;
        test_reset_mid_write;
        test_random;
        test_back_to_back;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
